vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 177 +++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position and lock status from a pair of
// active-low VGA sync signals that are synchronous to the pixel clock.
`timescale 1ns/1ps
module vga_sync_decoder #(
   parameter int Pixels_Horiz = 640,
   parameter int Pixels_Vert  = 480,
   parameter int HSync_Sync   = 96,
   parameter int HSync_Back   = 48,
   parameter int HSync_Total  = 800,
   parameter int VSync_Sync   = 2,
   parameter int VSync_Back   = 33,
   parameter int VSync_Total  = 525,
   parameter int Lock_Frames  = 2
)(
   input  logic        Master_Clock_In,
   input  logic        Reset_In,
   input  logic        Sync_Horiz_In,
   input  logic        Sync_Vert_In,
   output logic        Disp_Ena_Out,
   output logic [9:0]  Val_Col_Out,
   output logic [9:0]  Val_Row_Out,
   output logic        Locked_Out,
   output logic        Frame_Start_Out,
   output logic [11:0] Line_Len_Out,
   output logic [10:0] Frame_Lines_Out,
   output logic        Timing_Err_Out
);

   localparam logic [11:0] H_ACT_START = 12'(HSync_Sync + HSync_Back);
   localparam logic [11:0] H_ACT_END   = 12'(HSync_Sync + HSync_Back + Pixels_Horiz);
   localparam logic [11:0] H_TOTAL     = 12'(HSync_Total);
   localparam logic [10:0] V_ACT_START = 11'(VSync_Sync + VSync_Back);
   localparam logic [10:0] V_ACT_END   = 11'(VSync_Sync + VSync_Back + Pixels_Vert);
   localparam logic [10:0] V_TOTAL     = 11'(VSync_Total);
   localparam int          GW          = (Lock_Frames < 1) ? 1 : $clog2(Lock_Frames + 1);
   localparam logic [GW-1:0] LOCK_CNT  = GW'(Lock_Frames);

   typedef enum logic [1:0] {ST_UNLOCKED, ST_CHECK, ST_LOCKED} state_t;

   state_t          state_reg, state_next;
   logic [GW-1:0]   good_cnt_reg, good_cnt_next, good_inc;
   logic            timing_err_reg, timing_err_next;
   logic            arm_reg;
   logic            h_d_reg, v_d_reg;
   logic [11:0]     h_cnt_reg;
   logic [10:0]     v_cnt_reg;
   logic [11:0]     line_len_reg;
   logic [10:0]     frame_lines_reg;
   logic            line_seen_reg, bad_line_reg;

   logic            h_fall, v_fall, h_sat, line_bad, frame_good;
   logic [11:0]     h_len;
   logic [10:0]     v_close;
   logic            h_win, v_win, locked, disp;

   // arm_reg masks the first post-reset sample so that inputs already low at
   // release (h_d/v_d reset high) do not look like a falling edge
   assign h_fall   = arm_reg & h_d_reg & ~Sync_Horiz_In;
   assign v_fall   = arm_reg & v_d_reg & ~Sync_Vert_In;
   assign h_sat    = (h_cnt_reg == 12'hFFF);
   // a stalled line reports the largest representable length rather than wrapping
   assign h_len    = h_sat ? 12'hFFF : h_cnt_reg + 12'd1;
   assign v_close  = h_fall ? v_cnt_reg + 11'd1 : v_cnt_reg;
   assign line_bad = h_fall & line_seen_reg & (h_len != H_TOTAL);
   assign frame_good = ~bad_line_reg & ~line_bad & (v_close == V_TOTAL);
   assign good_inc = good_cnt_reg + 1'b1;

   // edge history, position counters, measured lengths and line-quality flags
   always_ff @(posedge Master_Clock_In) begin
      if (Reset_In) begin
         arm_reg         <= 1'b0;
         h_d_reg         <= 1'b1;
         v_d_reg         <= 1'b1;
         h_cnt_reg       <= '0;
         v_cnt_reg       <= '0;
         line_len_reg    <= '0;
         frame_lines_reg <= '0;
         line_seen_reg   <= 1'b0;
         bad_line_reg    <= 1'b0;
      end else begin
         arm_reg <= 1'b1;
         h_d_reg <= Sync_Horiz_In;
         v_d_reg <= Sync_Vert_In;
         if (h_fall) begin
            h_cnt_reg     <= '0;
            line_len_reg  <= h_len;
            line_seen_reg <= 1'b1;
         end else if (!h_sat) begin
            h_cnt_reg <= h_cnt_reg + 12'd1;
         end
         if (v_fall) begin
            v_cnt_reg       <= '0;
            frame_lines_reg <= v_close;
         end else if (h_fall && v_cnt_reg != 11'h7FF) begin
            v_cnt_reg <= v_cnt_reg + 11'd1;
         end
         // the closing edge has already been folded into frame_good, so clear here
         if (v_fall)
            bad_line_reg <= 1'b0;
         else if (line_bad)
            bad_line_reg <= 1'b1;
      end
   end

   // lock state register, good-frame counter and error pulse
   always_ff @(posedge Master_Clock_In) begin
      if (Reset_In) begin
         state_reg      <= ST_UNLOCKED;
         good_cnt_reg   <= '0;
         timing_err_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         good_cnt_reg   <= good_cnt_next;
         timing_err_reg <= timing_err_next;
      end
   end

   // lock qualification: count consecutive good frames, drop on any violation
   always_comb begin
      state_next      = state_reg;
      good_cnt_next   = good_cnt_reg;
      timing_err_next = 1'b0;
      case (state_reg)
         ST_UNLOCKED: begin
            if (v_fall) begin
               state_next    = ST_CHECK;
               good_cnt_next = '0;
            end
         end
         ST_CHECK: begin
            if (v_fall) begin
               if (frame_good) begin
                  good_cnt_next = good_inc;
                  if (good_inc >= LOCK_CNT)
                     state_next = ST_LOCKED;
               end else begin
                  good_cnt_next = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (line_bad || (v_cnt_reg > V_TOTAL) || (v_fall && !frame_good)) begin
               timing_err_next = 1'b1;
               state_next      = ST_CHECK;
               good_cnt_next   = '0;
            end
         end
         default: begin
            state_next    = ST_UNLOCKED;
            good_cnt_next = '0;
         end
      endcase
      // a line that never ends means the source is gone
      if (h_sat) begin
         state_next      = ST_UNLOCKED;
         good_cnt_next   = '0;
         timing_err_next = 1'b0;
      end
   end

   // position decode from the counter registers; everything forced low in reset
   always_comb begin
      h_win           = (h_cnt_reg >= H_ACT_START) && (h_cnt_reg < H_ACT_END);
      v_win           = (v_cnt_reg >= V_ACT_START) && (v_cnt_reg < V_ACT_END);
      locked          = (state_reg == ST_LOCKED) && !Reset_In;
      disp            = locked && h_win && v_win;
      Disp_Ena_Out    = disp;
      Locked_Out      = locked;
      Val_Col_Out     = disp ? 10'(h_cnt_reg - H_ACT_START) : 10'd0;
      Val_Row_Out     = disp ? 10'(v_cnt_reg - V_ACT_START) : 10'd0;
      Frame_Start_Out = disp && (h_cnt_reg == H_ACT_START) && (v_cnt_reg == V_ACT_START);
      Line_Len_Out    = Reset_In ? 12'd0 : line_len_reg;
      Frame_Lines_Out = Reset_In ? 11'd0 : frame_lines_reg;
      Timing_Err_Out  = timing_err_reg && !Reset_In;
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed sync streams with a per-cycle scoreboard,
// using a reduced timing (16 clocks x 12 lines) to keep frames short.
`timescale 1ns/1ps
module tb_vga_sync_decoder;

   localparam int PH = 8;
   localparam int HS = 2;
   localparam int HB = 3;
   localparam int HT = 16;
   localparam int PV = 6;
   localparam int VS = 1;
   localparam int VB = 2;
   localparam int VT = 12;
   localparam int HA = HS + HB;
   localparam int VA = VS + VB;

   typedef struct packed {
      logic        disp;
      logic [9:0]  col;
      logic [9:0]  row;
      logic        fs;
      logic        locked;
      logic        err;
      logic [11:0] len;
      logic [10:0] fl;
   } exp_t;

   logic        Master_Clock_In = 1'b0;
   logic        Reset_In = 1'b1;
   logic        Sync_Horiz_In = 1'b1;
   logic        Sync_Vert_In = 1'b1;
   logic        Disp_Ena_Out;
   logic [9:0]  Val_Col_Out;
   logic [9:0]  Val_Row_Out;
   logic        Locked_Out;
   logic        Frame_Start_Out;
   logic [11:0] Line_Len_Out;
   logic [10:0] Frame_Lines_Out;
   logic        Timing_Err_Out;

   int   compared = 0;
   int   mismatched = 0;
   exp_t sb_q[$];

   // stream model state
   int   last_len;
   int   next_fl;
   bit   locked_m;
   int   line_len_m;
   int   frame_lines_m;

   vga_sync_decoder #(
      .Pixels_Horiz(PH), .Pixels_Vert(PV),
      .HSync_Sync(HS), .HSync_Back(HB), .HSync_Total(HT),
      .VSync_Sync(VS), .VSync_Back(VB), .VSync_Total(VT),
      .Lock_Frames(2)
   ) dut (
      .Master_Clock_In(Master_Clock_In),
      .Reset_In(Reset_In),
      .Sync_Horiz_In(Sync_Horiz_In),
      .Sync_Vert_In(Sync_Vert_In),
      .Disp_Ena_Out(Disp_Ena_Out),
      .Val_Col_Out(Val_Col_Out),
      .Val_Row_Out(Val_Row_Out),
      .Locked_Out(Locked_Out),
      .Frame_Start_Out(Frame_Start_Out),
      .Line_Len_Out(Line_Len_Out),
      .Frame_Lines_Out(Frame_Lines_Out),
      .Timing_Err_Out(Timing_Err_Out)
   );

   always #5 Master_Clock_In = ~Master_Clock_In;

   initial begin
      #1ms;
      $display("FAIL timeout: observed no finish, expected finish before 1ms");
      $fatal(1, "timeout");
   end

   function automatic exp_t observe();
      exp_t o;
      o = {Disp_Ena_Out, Val_Col_Out, Val_Row_Out, Frame_Start_Out, Locked_Out,
           Timing_Err_Out, Line_Len_Out, Frame_Lines_Out};
      return o;
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      assert (act === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step(input logic hs, input logic vs);
      Sync_Horiz_In = hs;
      Sync_Vert_In  = vs;
      @(posedge Master_Clock_In);
      #1;
   endtask

   // drive n_lines of a frame; line bad_l (if >= 0) is one clock too long
   task automatic run_frame(input int bad_l, input bit lock_start, input int n_lines);
      exp_t e;
      exp_t o;
      for (int l = 0; l < n_lines; l++) begin
         int len;
         len = (l == bad_l) ? HT + 1 : HT;
         for (int p = 0; p < len; p++) begin
            e = '0;
            if (p == 0) begin
               line_len_m = last_len;
               if (l == 0) begin
                  frame_lines_m = next_fl;
                  next_fl = VT;
                  if (lock_start) locked_m = 1'b1;
               end
               if (bad_l >= 0 && l == bad_l + 1 && locked_m) begin
                  locked_m = 1'b0;
                  e.err = 1'b1;
               end
            end
            e.locked = locked_m;
            e.len    = 12'(line_len_m);
            e.fl     = 11'(frame_lines_m);
            if (locked_m && p >= HA && p < HA + PH && l >= VA && l < VA + PV) begin
               e.disp = 1'b1;
               e.col  = 10'(p - HA);
               e.row  = 10'(l - VA);
               e.fs   = (p == HA) && (l == VA);
            end
            sb_q.push_back(e);
            step((p < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1);
            o = observe();
            e = sb_q.pop_front();
            check($sformatf("stream l%0d p%0d", l, p), 64'(o), 64'(e));
            if (p == 0) check($sformatf("v_cnt l%0d", l), 64'(dut.v_cnt_reg), 64'(l));
         end
         last_len = len;
      end
   endtask

   initial begin
      // reset with syncs idle high
      Reset_In = 1'b1;
      #1;
      check("reset_comb", 64'(observe()), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1);
         check("reset_hold", 64'(observe()), 64'd0);
      end
      check("reset_h_cnt", 64'(dut.h_cnt_reg), 64'd0);
      Reset_In = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         step(1'b1, 1'b1);
         check("idle_h_cnt", 64'(dut.h_cnt_reg), 64'(i));
         check("idle_out", 64'(observe()), 64'd0);
      end

      // acquire lock, lose it on an 801-style long line, reacquire
      last_len = 3; next_fl = 1; locked_m = 1'b0; line_len_m = 0; frame_lines_m = 0;
      run_frame(-1, 1'b0, VT);
      run_frame(-1, 1'b0, VT);
      run_frame(-1, 1'b1, VT);
      run_frame(4,  1'b0, VT);
      run_frame(-1, 1'b0, VT);
      run_frame(-1, 1'b0, VT);
      run_frame(-1, 1'b1, VT);
      run_frame(-1, 1'b0, 5);
      check("locked_before_reset", 64'(Locked_Out), 64'd1);

      // mid-frame reset with both syncs low, then held low after release
      Reset_In = 1'b1;
      Sync_Horiz_In = 1'b0;
      Sync_Vert_In = 1'b0;
      #1;
      check("midrst_comb", 64'(observe()), 64'd0);
      step(1'b0, 1'b0);
      check("midrst_edge", 64'(observe()), 64'd0);
      check("midrst_state", 64'(dut.state_reg), 64'd0);
      Reset_In = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step(1'b0, 1'b0);
         check("low_h_cnt", 64'(dut.h_cnt_reg), 64'(i));
         check("low_line_len", 64'(Line_Len_Out), 64'd0);
         check("low_v_cnt", 64'(dut.v_cnt_reg), 64'd0);
      end
      for (int i = 6; i <= 8; i++) begin
         step(1'b1, 1'b1);
         check("rise_h_cnt", 64'(dut.h_cnt_reg), 64'(i));
         check("rise_line_len", 64'(Line_Len_Out), 64'd0);
      end

      // relock, then stall hsync so the line counter saturates
      last_len = 9; next_fl = 1; locked_m = 1'b0;
      run_frame(-1, 1'b0, VT);
      run_frame(-1, 1'b0, VT);
      run_frame(-1, 1'b1, VT);
      for (int i = 0; i < 5000; i++) step(1'b1, 1'b1);
      check("stall_h_cnt", 64'(dut.h_cnt_reg), 64'd4095);
      check("stall_locked", 64'(Locked_Out), 64'd0);
      check("stall_disp", 64'(Disp_Ena_Out), 64'd0);
      check("stall_err", 64'(Timing_Err_Out), 64'd0);
      check("stall_state", 64'(dut.state_reg), 64'd0);
      step(1'b1, 1'b1);
      check("stall_h_cnt_hold", 64'(dut.h_cnt_reg), 64'd4095);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
